// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequences one signed divide through an external combinational
// alu_div. The operands are registered, the block waits SETTLE_CYCLES for the
// divider path to settle, and then it captures the quotient into LO and the
// remainder into HI.
// Optional feature: define DIV_ZERO_CHECK_EN to short-circuit B == 0 requests.
// Such a request reports dbz and does not enter WAIT.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no operation in flight; start is sampled here
// WAIT  | operands held on div_A/div_B; counter runs down to the capture edge
`timescale 1ns/1ps

module div_seq_ctrl #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [31:0] div_Q,
   input  logic [31:0] div_R,
   output logic [31:0] div_A,
   output logic [31:0] div_B,
   output logic [31:0] LO,
   output logic [31:0] HI,
   output logic        busy,
   output logic        done,
   output logic        dbz
);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   // The count starts at SETTLE_CYCLES-1 so that the capture happens on the
   // SETTLE_CYCLES-th edge after start.
   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   state_t     next_state;
   logic [3:0] cnt;
   logic       load_op;
   logic       capture;
   logic       zero_skip;

   // State register
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic and datapath strobes
   always_comb begin
      next_state = state;
      load_op    = 1'b0;
      capture    = 1'b0;
      zero_skip  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load_op = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
               if (B == 32'd0) zero_skip  = 1'b1;
               else            next_state = WAIT;
`else
               next_state = WAIT;
`endif
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               capture    = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Operand registers, settle counter, result capture and done pulse
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         div_A <= 32'd0;
         div_B <= 32'd0;
         cnt   <= 4'd0;
         LO    <= 32'd0;
         HI    <= 32'd0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load_op) begin
            div_A <= A;
            div_B <= B;
            cnt   <= zero_skip ? 4'd0 : CNT_INIT;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (capture) begin
            LO   <= div_Q;
            HI   <= div_R;
            done <= 1'b1;
         end
         if (zero_skip) done <= 1'b1;
      end
   end

`ifdef DIV_ZERO_CHECK_EN
   logic dbz_q;

   // dbz is set by a zero-divisor request and cleared by the next real capture
   always_ff @(posedge clock or negedge clear) begin
      if (!clear)         dbz_q <= 1'b0;
      else if (zero_skip) dbz_q <= 1'b1;
      else if (capture)   dbz_q <= 1'b0;
   end

   assign dbz = dbz_q;
`else
   assign dbz = 1'b0;
`endif

   assign busy = (state == WAIT);

endmodule

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, legal range 1..15, giving the cycles allowed for the combinational divider path to settle.
REQ-002 clock  input  1  the single system clock; all state SHALL update on its rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a divide; sampled only in IDLE.
REQ-005 A  input  32  dividend, two's complement.
REQ-006 B  input  32  divisor, two's complement.
REQ-007 div_Q  input  32  quotient returned by the external alu_div.
REQ-008 div_R  input  32  remainder returned by the external alu_div.
REQ-009 div_A  output  32  registered dividend driven to alu_div.
REQ-010 div_B  output  32  registered divisor driven to alu_div.
REQ-011 LO  output  32  captured quotient.
REQ-012 HI  output  32  captured remainder.
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 dbz  output  1  divide-by-zero flag; valid while done is high.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and WAIT.
REQ-017 In IDLE with start=1 at edge k:
- div_A/div_B SHALL load A/B.
- A 4-bit counter SHALL load SETTLE_CYCLES-1.
- The FSM SHALL move to WAIT.
REQ-018 In WAIT, div_A/div_B SHALL hold constant, and the counter SHALL decrement by 1 per edge while it is nonzero.
REQ-019 At the WAIT edge where the counter equals 0:
- LO SHALL load div_Q.
- HI SHALL load div_R.
- done SHALL be set to 1 for exactly one cycle.
- The FSM SHALL return to IDLE.
REQ-020 Latency: done and the new HI/LO SHALL be visible exactly SETTLE_CYCLES cycles after edge k; with the default, done rises after edge k+4.
REQ-021 busy SHALL be 1 from edge k until the capture edge, and 0 otherwise.
REQ-022 start while busy=1 SHALL be ignored: no queuing, and operands are not re-sampled.
REQ-023 start=1 in the same cycle done=1 SHALL be accepted, because the FSM is already in IDLE; back-to-back throughput is one result per SETTLE_CYCLES+1 cycles.
REQ-024 HI/LO SHALL hold their values between captures; they SHALL change only on a capture edge or on reset.
REQ-025 Arithmetic SHALL be performed entirely by the external alu_div; this block SHALL NOT modify, sign-adjust or widen div_Q/div_R.
REQ-026 A change on A/B while busy SHALL have no effect on the result.

Reset
REQ-027 While clear=0, regardless of clock: FSM=IDLE, counter=0, and div_A=div_B=LO=HI=0.
REQ-028 While clear=0: busy=0, done=0, dbz=0.
REQ-029 Reset asserted mid-operation SHALL abort it with no capture and no done pulse.
REQ-030 After clear deasserts, the first start SHALL be sampled at the first rising edge.

Configuration
REQ-031 With macro DIV_ZERO_CHECK_EN defined, start in IDLE with B=0 SHALL skip WAIT:
- done=1 and dbz=1 on the next cycle.
- HI/LO unchanged.
- busy SHALL stay 0.
- div_A/div_B SHALL still load.
REQ-032 With DIV_ZERO_CHECK_EN defined, a division with nonzero B SHALL clear dbz to 0 at its capture edge.
REQ-033 Without DIV_ZERO_CHECK_EN, B=0 SHALL run the normal WAIT sequence and capture whatever alu_div returns; dbz SHALL be tied to 0.

Verification
REQ-034 The bench SHALL connect the block to alu_div (div_A/div_B to A/B, Q/R to div_Q/div_R) with SETTLE_CYCLES=4 and cover these scenarios:
- V1: A=0xE, B=0x5, start for one cycle -> after 4 cycles done=1, LO=0x2, HI=0x4, busy=1 for exactly 4 cycles.
- V2: A=0x4D2, B=0xFFFFFF84 -> LO=0xFFFFFFF7, HI=0x76; A=0xFFFFFFF2, B=0x5 -> LO=0xFFFFFFFE, HI=0xFFFFFFFC.
- V3: start A=0x28, B=0xA, then change A/B and pulse start at cycle 2 -> LO=0x4, HI=0x0, and exactly one done pulse.
- V4: start asserted again in the done cycle with A=0xFC, B=0xFFFFFFFC -> accepted; next done after 4 cycles with LO=0xFFFFFFC1, HI=0x0.
- V5: clear driven low mid-WAIT -> all outputs 0 immediately, no done pulse; after release, V1 repeats correctly.
- V6: with DIV_ZERO_CHECK_EN, B=0 -> done=1 and dbz=1 on the next cycle, HI/LO unchanged; without the macro -> WAIT runs the full 4 cycles and dbz=0.
